// File: rtl/int8_quad_mac_seq.sv
// Sequencer that streams INT8 activations into four external MAC lanes
// sharing one activation, and returns the four accumulated sums.
module int8_quad_mac_seq #(
    parameter int WXYZ_BITS = 32,
    parameter int LEN_BITS  = 16,
    parameter int MUL_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [LEN_BITS-1:0]  cfg_len,
    input  logic [7:0]           cfg_wa,
    input  logic [7:0]           cfg_wb,
    input  logic [7:0]           cfg_wc,
    input  logic [7:0]           cfg_wd,
    input  logic                 act_valid,
    output logic                 act_ready,
    input  logic [7:0]           act_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WXYZ_BITS-1:0] res_w,
    output logic [WXYZ_BITS-1:0] res_x,
    output logic [WXYZ_BITS-1:0] res_y,
    output logic [WXYZ_BITS-1:0] res_z,
    output logic                 busy,
    output logic [7:0]           mac_a,
    output logic [7:0]           mac_b,
    output logic [7:0]           mac_c,
    output logic [7:0]           mac_d,
    output logic [7:0]           mac_e,
    output logic [WXYZ_BITS-1:0] mac_s,
    output logic [WXYZ_BITS-1:0] mac_t,
    output logic [WXYZ_BITS-1:0] mac_u,
    output logic [WXYZ_BITS-1:0] mac_v,
    input  logic [WXYZ_BITS-1:0] mac_w,
    input  logic [WXYZ_BITS-1:0] mac_x,
    input  logic [WXYZ_BITS-1:0] mac_y,
    input  logic [WXYZ_BITS-1:0] mac_z
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_OUT
    } state_t;

    localparam logic [LEN_BITS-1:0] L_ONE = LEN_BITS'(1);

    state_t r_state;
    state_t w_next;

    logic                 w_cfg_hs;
    logic                 w_act_hs;
    logic                 w_last;
    logic                 w_drain_done;
    logic                 w_first;
    logic                 w_tag;
    logic                 w_clr;
    logic [LEN_BITS-1:0]  r_len;
    logic [LEN_BITS-1:0]  r_cnt;
    logic [2:0]           r_drn;
    logic [7:0]           r_wa;
    logic [7:0]           r_wb;
    logic [7:0]           r_wc;
    logic [7:0]           r_wd;
    logic [WXYZ_BITS-1:0] r_rw;
    logic [WXYZ_BITS-1:0] r_rx;
    logic [WXYZ_BITS-1:0] r_ry;
    logic [WXYZ_BITS-1:0] r_rz;

    assign w_cfg_hs     = cfg_valid & cfg_ready;
    assign w_act_hs     = act_valid & act_ready;
    assign w_last       = (r_cnt == r_len - L_ONE);
    assign w_drain_done = (r_drn == 3'(MUL_LAT));
    assign w_first      = w_act_hs & (r_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Handshake terms are rebuilt from raw inputs here to avoid a comb loop.
    always_comb begin
        w_next    = r_state;
        cfg_ready = 1'b0;
        act_ready = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                busy      = 1'b0;
                cfg_ready = rst;
                if (cfg_valid && rst) begin
                    w_next = (cfg_len != '0) ? S_RUN : S_OUT;
                end
            end
            S_RUN: begin
                act_ready = 1'b1;
                if (act_valid && w_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_done) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len <= '0;
            r_cnt <= '0;
            r_drn <= '0;
            r_wa  <= '0;
            r_wb  <= '0;
            r_wc  <= '0;
            r_wd  <= '0;
            r_rw  <= '0;
            r_rx  <= '0;
            r_ry  <= '0;
            r_rz  <= '0;
        end else begin
            if (w_cfg_hs) begin
                r_len <= cfg_len;
                r_cnt <= '0;
                r_drn <= '0;
                r_wa  <= cfg_wa;
                r_wb  <= cfg_wb;
                r_wc  <= cfg_wc;
                r_wd  <= cfg_wd;
                if (cfg_len == '0) begin
                    r_rw <= '0;
                    r_rx <= '0;
                    r_ry <= '0;
                    r_rz <= '0;
                end
            end
            if (w_act_hs) begin
                r_cnt <= r_cnt + L_ONE;
            end
            if (r_state == S_DRAIN) begin
                if (w_drain_done) begin
                    r_rw <= mac_w;
                    r_rx <= mac_x;
                    r_ry <= mac_y;
                    r_rz <= mac_z;
                end else begin
                    r_drn <= r_drn + 3'd1;
                end
            end
        end
    end

    // The first-element tag travels alongside the product pipeline.
    generate
        if (MUL_LAT == 0) begin : g_tag0
            assign w_tag = w_first;
        end else begin : g_tagn
            logic [MUL_LAT-1:0] r_tag;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_tag <= '0;
                end else begin
                    r_tag[0] <= w_first;
                    for (int i = 1; i < MUL_LAT; i++) begin
                        r_tag[i] <= r_tag[i-1];
                    end
                end
            end
            assign w_tag = r_tag[MUL_LAT-1];
        end
    endgenerate

    assign w_clr = w_tag | ~rst;

    assign mac_a = r_wa;
    assign mac_b = r_wb;
    assign mac_c = r_wc;
    assign mac_d = r_wd;
    assign mac_e = w_act_hs ? act_data : 8'd0;
    assign mac_s = w_clr ? '0 : mac_w;
    assign mac_t = w_clr ? '0 : mac_x;
    assign mac_u = w_clr ? '0 : mac_y;
    assign mac_v = w_clr ? '0 : mac_z;

    assign res_w = r_rw;
    assign res_x = r_rx;
    assign res_y = r_ry;
    assign res_z = r_rz;

endmodule
